lwe_op_sequencer: RTL

- Parametrised successor to the single-command LWE op controller.
- Accepts queued ENCRYPT/DECRYPT/ADD/MULT commands over a valid/ready interface and stores them in an internal FIFO.
- Generates per-beat operand and result addresses for PARALLEL lanes, stalls on downstream backpressure, and drains the datapath pipeline before pulsing done.
- Sits between the host command port and the LWE datapath/memory banks.

---
 rtl/lwe_pkg.sv | 22 ++
 rtl/lwe_cmd_fifo.sv | 47 ++++
 rtl/lwe_op_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lwe_pkg.sv
// Shared opcodes, FSM state encoding and command sizing
// for the LWE op sequencer and its command FIFO.
package lwe_pkg;

  localparam logic [1:0] OPCODE_ENCRYPT = 2'd0;
  localparam logic [1:0] OPCODE_DECRYPT = 2'd1;
  localparam logic [1:0] OPCODE_ADD     = 2'd2;
  localparam logic [1:0] OPCODE_MULT    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } seq_state_t;

  // Packed command: {opcode, op1_base, op2_base, out_base, noise}
  function automatic int cmd_w(input int aw, input int bn);
    return 2 + 3 * aw + bn;
  endfunction

endpackage

// File: rtl/lwe_cmd_fifo.sv
// Show-ahead synchronous FIFO holding queued sequencer commands.
// Pushes into a full FIFO are dropped; pops from empty are ignored.
module lwe_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty   = wr_ptr == rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Read/write pointers with wrap bit for full/empty detection
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/lwe_op_sequencer.sv
// Queued LWE command sequencer: per-beat address generation for
// PARALLEL lanes. Optional perf counters under LWE_SEQ_PERF_EN.
module lwe_op_sequencer #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int DIMENSION        = 10,
  parameter int BIG_N            = 30,
  parameter int DIM_WIDTH        = 4,
  parameter int ADDR_WIDTH       = 10,
  parameter int PARALLEL         = 2,
  parameter int CMD_DEPTH        = 4,
  parameter int PIPE_LAT         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_base,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_base,
  input  logic [ADDR_WIDTH-1:0] cmd_out_base,
  input  logic [BIG_N-1:0]      cmd_noise,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [1:0]            opcode_out,
  output logic [ADDR_WIDTH-1:0] op1_addr,
  output logic [ADDR_WIDTH-1:0] op2_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  op_select,
  output logic [PARALLEL-1:0]   lane_mask,
  output logic [PARALLEL-1:0]   noise_bits,
  output logic [DIM_WIDTH-1:0]  row,
  output logic                  last_col,
  output logic                  busy,
  output logic                  done
`ifdef LWE_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
`endif
);

  import lwe_pkg::*;

  localparam int VEC_LEN = DIMENSION + 1;
  localparam int CMD_W   = cmd_w(ADDR_WIDTH, BIG_N);
  localparam int IW      = $clog2(BIG_N + VEC_LEN + PARALLEL + 1);
  localparam int DW      = $clog2(PIPE_LAT + 2);

  localparam logic [IW-1:0] I_STEP   = IW'(PARALLEL);
  localparam logic [IW-1:0] COL_LAST = IW'(BIG_N - PARALLEL);
  localparam logic [IW-1:0] K_LAST   = IW'(VEC_LEN - PARALLEL);
  localparam logic [DIM_WIDTH-1:0] ROW_LAST = DIM_WIDTH'(DIMENSION - 1);
  localparam logic [DIM_WIDTH-1:0] ROW_ONE  = DIM_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_STEP = ADDR_WIDTH'(PARALLEL);
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT);

  seq_state_t state;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_dout;

  logic [1:0]            c_op;
  logic [ADDR_WIDTH-1:0] c_op1b;
  logic [ADDR_WIDTH-1:0] c_op2b;
  logic [ADDR_WIDTH-1:0] c_outb;
  logic [BIG_N-1:0]      c_noise;

  logic [IW-1:0] idx;
  logic [DW-1:0] drain_cnt;

  logic is_enc, is_dec, is_add, is_mul;

  logic [IW-1:0]         n_idx;
  logic [DIM_WIDTH-1:0]  n_row;
  logic                  n_phase;
  logic [ADDR_WIDTH-1:0] n_op1;
  logic [ADDR_WIDTH-1:0] n_op2;
  logic [ADDR_WIDTH-1:0] n_out;
  logic [PARALLEL-1:0]   n_mask;
  logic [PARALLEL-1:0]   n_noise;
  logic                  n_last_col;
  logic                  fin;

  function automatic logic [PARALLEL-1:0] mask_f(
    input logic enc, input logic [IW-1:0] k);
    logic [PARALLEL-1:0] m;
    for (int i = 0; i < PARALLEL; i++)
      m[i] = enc || ((int'(k) + i) < VEC_LEN);
    return m;
  endfunction

  function automatic logic [PARALLEL-1:0] noise_f(
    input logic enc, input logic [BIG_N-1:0] nz,
    input logic [IW-1:0] col);
    logic [BIG_N-1:0] sh;
    sh = nz >> col;
    return enc ? sh[PARALLEL-1:0] : '0;
  endfunction

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign busy      = (state != S_IDLE);

  assign is_enc = (c_op == OPCODE_ENCRYPT);
  assign is_dec = (c_op == OPCODE_DECRYPT);
  assign is_add = (c_op == OPCODE_ADD);
  assign is_mul = (c_op == OPCODE_MULT);

  lwe_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .pop   (fifo_pop),
    .din   ({cmd_opcode, cmd_op1_base, cmd_op2_base,
             cmd_out_base, cmd_noise}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-beat counters/addresses and whether this beat is the last
  always_comb begin
    n_idx   = idx;
    n_row   = row;
    n_phase = op_select;
    n_op1   = op1_addr;
    n_op2   = op2_addr;
    n_out   = out_addr;
    fin     = 1'b0;
    unique case (1'b1)
      is_enc: begin
        n_op1 = op1_addr + A_STEP;
        if (idx == COL_LAST) begin
          n_idx = '0;
          n_row = row + ROW_ONE;
          n_op2 = c_op2b;
          n_out = out_addr + A_ONE;
          fin   = (row == ROW_LAST);
        end else begin
          n_idx = idx + I_STEP;
          n_op2 = op2_addr + A_STEP;
        end
      end
      is_dec, is_add: begin
        n_idx = idx + I_STEP;
        n_row = row + ROW_ONE;
        n_op1 = op1_addr + A_STEP;
        n_op2 = op2_addr + A_STEP;
        if (is_add) n_out = out_addr + A_STEP;
        fin   = (idx >= K_LAST);
      end
      is_mul: begin
        n_out = out_addr + A_STEP;
        if (!op_select) begin
          n_op1 = op1_addr + A_STEP;
          if (idx >= K_LAST) begin
            n_idx   = '0;
            n_row   = '0;
            n_phase = 1'b1;
          end else begin
            n_idx = idx + I_STEP;
            n_row = row + ROW_ONE;
          end
        end else begin
          n_op2 = op2_addr + A_STEP;
          n_idx = idx + I_STEP;
          n_row = row + ROW_ONE;
          fin   = (idx >= K_LAST);
        end
      end
    endcase
    n_mask     = mask_f(is_enc, n_idx);
    n_noise    = noise_f(is_enc, c_noise, n_idx);
    n_last_col = is_enc && (n_idx == COL_LAST);
  end

  // Command FSM with registered beat outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      c_op        <= '0;
      c_op1b      <= '0;
      c_op2b      <= '0;
      c_outb      <= '0;
      c_noise     <= '0;
      idx         <= '0;
      drain_cnt   <= '0;
      issue_valid <= 1'b0;
      opcode_out  <= '0;
      op1_addr    <= '0;
      op2_addr    <= '0;
      out_addr    <= '0;
      op_select   <= 1'b0;
      lane_mask   <= '0;
      noise_bits  <= '0;
      row         <= '0;
      last_col    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            {c_op, c_op1b, c_op2b, c_outb, c_noise} <= fifo_dout;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          opcode_out  <= c_op;
          op1_addr    <= c_op1b;
          op2_addr    <= c_op2b;
          out_addr    <= c_outb;
          idx         <= '0;
          row         <= '0;
          op_select   <= 1'b0;
          issue_valid <= 1'b1;
          lane_mask   <= mask_f(is_enc, '0);
          noise_bits  <= noise_f(is_enc, c_noise, '0);
          last_col    <= is_enc && (COL_LAST == '0);
          state       <= S_RUN;
        end
        S_RUN: begin
          if (issue_ready) begin
            if (fin) begin
              issue_valid <= 1'b0;
              lane_mask   <= '0;
              last_col    <= 1'b0;
              drain_cnt   <= DRAIN_INIT;
              state       <= S_DRAIN;
            end else begin
              idx        <= n_idx;
              row        <= n_row;
              op_select  <= n_phase;
              op1_addr   <= n_op1;
              op2_addr   <= n_op2;
              out_addr   <= n_out;
              lane_mask  <= n_mask;
              noise_bits <= n_noise;
              last_col   <= n_last_col;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LWE_SEQ_PERF_EN
  // Saturating busy and stall cycle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 1'b1;
      if (issue_valid && !issue_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif

endmodule
